// File: rtl/mem_resp_stage.sv
// mem_resp_stage: MEM pipeline stage for a variable-latency data SRAM
// (req/addr_ok/data_ok). Holds each instruction until its response returns,
// buffers a response that arrives while WB stalls, discards responses that
// belong to flushed instructions, and performs load select/extension.
// Optional feature macro: MS_LWLR_EN (unaligned LWL/LWR support, little-endian).
// When MS_LWLR_EN is undefined, ops 101/110 behave as LW.
module mem_resp_stage #(
  parameter int PC_W     = 32,
  parameter int DEST_W   = 5,
  parameter int CANCEL_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              ws_allowin,
  output logic              ms_allowin,
  input  logic              es_to_ms_valid,
  input  logic              es_mem_req,
  input  logic              es_res_from_mem,
  input  logic [2:0]        es_ld_op,
  input  logic              es_gr_we,
  input  logic [DEST_W-1:0] es_dest,
  input  logic [31:0]       es_alu_result,
  input  logic [PC_W-1:0]   es_pc,
  input  logic              data_ok,
  input  logic [31:0]       rdata,
  output logic              ms_to_ws_valid,
  output logic [3:0]        ms_gr_we,
  output logic [DEST_W-1:0] ms_dest,
  output logic [31:0]       ms_result,
  output logic [PC_W-1:0]   ms_pc,
  output logic              ms_fwd_valid,
  output logic              ms_fwd_ready
);

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_LH  = 3'b011;
  localparam logic [2:0] OP_LHU = 3'b100;
`ifdef MS_LWLR_EN
  localparam logic [2:0] OP_LWL = 3'b101;
  localparam logic [2:0] OP_LWR = 3'b110;
`endif

  localparam logic [CANCEL_W:0] CNT_ONE = {{CANCEL_W{1'b0}}, 1'b1};

  // Stage state
  logic                ms_valid_reg;
  logic                buf_valid_reg;
  logic [31:0]         buf_rdata_reg;
  logic [CANCEL_W-1:0] cancel_cnt_reg;

  // Instruction payload
  logic                ms_mem_req_reg;
  logic                ms_res_from_mem_reg;
  logic [2:0]          ms_ld_op_reg;
  logic                ms_gr_we_1_reg;
  logic [DEST_W-1:0]   ms_dest_reg;
  logic [31:0]         ms_alu_result_reg;
  logic [PC_W-1:0]     ms_pc_reg;

  // Handshake helpers
  logic                resp_owned;   // response belongs to the current MEM instr
  logic                resp_drop;    // response belongs to a flushed instr
  logic                ms_ready_go;
  logic                ms_latch;
  logic                ms_leave;
  logic                buf_capture;
  logic                cancel_inc_mem;
  logic                cancel_inc_ex;
  logic [CANCEL_W:0]   cancel_sum;   // one extra bit to expose overflow

  // Load formatting
  logic [31:0]         load_word;
  logic [1:0]          off;
  logic [7:0]          load_byte;
  logic [15:0]         load_half;
  logic [31:0]         load_data;
  logic [3:0]          we_mask;

  assign resp_drop      = data_ok && (cancel_cnt_reg != '0);
  assign resp_owned     = data_ok && (cancel_cnt_reg == '0);
  assign ms_ready_go    = !ms_mem_req_reg || buf_valid_reg || resp_owned;
  assign ms_allowin     = !ms_valid_reg || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid_reg && ms_ready_go && !flush;
  assign ms_leave       = ms_to_ws_valid && ws_allowin;
  assign ms_latch       = es_to_ms_valid && ms_allowin && !flush;

  // A response that arrives while WB is stalled must be held locally,
  // because the SRAM presents rdata for one cycle only.
  assign buf_capture = ms_valid_reg && ms_mem_req_reg && !buf_valid_reg &&
                       resp_owned && !ws_allowin;

  // On flush, every outstanding request whose response has not been seen
  // yet becomes a stale response that must be swallowed later.
  assign cancel_inc_mem = flush && ms_valid_reg && ms_mem_req_reg &&
                          !buf_valid_reg && !resp_owned;
  assign cancel_inc_ex  = flush && es_to_ms_valid && es_mem_req;

  // Valid bit: flush kills the stage; otherwise refill whenever allowed.
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid_reg <= 1'b0;
    end else if (flush) begin
      ms_valid_reg <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid_reg <= es_to_ms_valid;
    end
  end

  // Payload registers take the EX instruction when it is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_mem_req_reg      <= 1'b0;
      ms_res_from_mem_reg <= 1'b0;
      ms_ld_op_reg        <= 3'b000;
      ms_gr_we_1_reg      <= 1'b0;
      ms_dest_reg         <= '0;
      ms_alu_result_reg   <= 32'h0;
      ms_pc_reg           <= '0;
    end else if (ms_latch) begin
      ms_mem_req_reg      <= es_mem_req;
      ms_res_from_mem_reg <= es_res_from_mem;
      ms_ld_op_reg        <= es_ld_op;
      ms_gr_we_1_reg      <= es_gr_we;
      ms_dest_reg         <= es_dest;
      ms_alu_result_reg   <= es_alu_result;
      ms_pc_reg           <= es_pc;
    end
  end

  // Response buffer: filled on a stalled owned response, emptied on hand-off or flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid_reg <= 1'b0;
      buf_rdata_reg <= 32'h0;
    end else if (flush || ms_leave) begin
      buf_valid_reg <= 1'b0;
    end else if (buf_capture) begin
      buf_valid_reg <= 1'b1;
      buf_rdata_reg <= rdata;
    end
  end

  // Stale-response counter next value: increments and a decrement net out.
  always_comb begin
    cancel_sum = {1'b0, cancel_cnt_reg};
    if (cancel_inc_mem) cancel_sum = cancel_sum + CNT_ONE;
    if (cancel_inc_ex)  cancel_sum = cancel_sum + CNT_ONE;
    if (resp_drop)      cancel_sum = cancel_sum - CNT_ONE;
  end

  // Stale-response counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cancel_cnt_reg <= '0;
    end else begin
      cancel_cnt_reg <= cancel_sum[CANCEL_W-1:0];
    end
  end

  // More pending cancels than the counter can hold would lose track of stale data.
  cancel_no_overflow: assert property (@(posedge clk) disable iff (reset)
                                       !cancel_sum[CANCEL_W]);

  // Load select/extension and per-byte write mask.
  always_comb begin
    load_word = buf_valid_reg ? buf_rdata_reg : rdata;
    off       = ms_alu_result_reg[1:0];
    case (off)
      2'd0:    load_byte = load_word[7:0];
      2'd1:    load_byte = load_word[15:8];
      2'd2:    load_byte = load_word[23:16];
      default: load_byte = load_word[31:24];
    endcase
    load_half = off[1] ? load_word[31:16] : load_word[15:0];
    load_data = load_word;
    we_mask   = 4'b1111;
    case (ms_ld_op_reg)
      OP_LW:  load_data = load_word;
      OP_LB:  load_data = {{24{load_byte[7]}}, load_byte};
      OP_LBU: load_data = {24'h0, load_byte};
      OP_LH:  load_data = {{16{load_half[15]}}, load_half};
      OP_LHU: load_data = {16'h0, load_half};
`ifdef MS_LWLR_EN
      OP_LWL: begin
        case (off)
          2'd0: begin load_data = {load_word[7:0], 24'h0};  we_mask = 4'b1000; end
          2'd1: begin load_data = {load_word[15:0], 16'h0}; we_mask = 4'b1100; end
          2'd2: begin load_data = {load_word[23:0], 8'h0};  we_mask = 4'b1110; end
          default: begin load_data = load_word;             we_mask = 4'b1111; end
        endcase
      end
      OP_LWR: begin
        case (off)
          2'd0: begin load_data = load_word;                 we_mask = 4'b1111; end
          2'd1: begin load_data = {8'h0, load_word[31:8]};   we_mask = 4'b0111; end
          2'd2: begin load_data = {16'h0, load_word[31:16]}; we_mask = 4'b0011; end
          default: begin load_data = {24'h0, load_word[31:24]}; we_mask = 4'b0001; end
        endcase
      end
`endif
      default: load_data = load_word;
    endcase
  end

  assign ms_result    = ms_res_from_mem_reg ? load_data : ms_alu_result_reg;
  assign ms_gr_we     = ms_gr_we_1_reg ? we_mask : 4'b0000;
  assign ms_dest      = ms_dest_reg;
  assign ms_pc        = ms_pc_reg;
  assign ms_fwd_valid = ms_valid_reg && (|ms_gr_we);
  // Gated by valid so an empty stage never advertises a forwardable result.
  assign ms_fwd_ready = ms_valid_reg && ms_ready_go;

endmodule

// File: tb/tb_mem_resp_stage.sv
// tb_mem_resp_stage: directed bench for mem_resp_stage with a transaction-level
// expected-writeback queue, a per-cycle WB compare process and literal checks.
module tb_mem_resp_stage;
  localparam int PC_W = 32;
  localparam int DEST_W = 5;
  localparam int CANCEL_W = 2;

  logic              clk = 1'b0;
  logic              reset, flush, ws_allowin, ms_allowin;
  logic              es_to_ms_valid, es_mem_req, es_res_from_mem, es_gr_we;
  logic [2:0]        es_ld_op;
  logic [DEST_W-1:0] es_dest;
  logic [31:0]       es_alu_result;
  logic [PC_W-1:0]   es_pc;
  logic              data_ok;
  logic [31:0]       rdata;
  logic              ms_to_ws_valid, ms_fwd_valid, ms_fwd_ready;
  logic [3:0]        ms_gr_we;
  logic [DEST_W-1:0] ms_dest;
  logic [31:0]       ms_result;
  logic [PC_W-1:0]   ms_pc;

  mem_resp_stage #(.PC_W(PC_W), .DEST_W(DEST_W), .CANCEL_W(CANCEL_W)) dut (
    .clk(clk), .reset(reset), .flush(flush), .ws_allowin(ws_allowin),
    .ms_allowin(ms_allowin), .es_to_ms_valid(es_to_ms_valid),
    .es_mem_req(es_mem_req), .es_res_from_mem(es_res_from_mem),
    .es_ld_op(es_ld_op), .es_gr_we(es_gr_we), .es_dest(es_dest),
    .es_alu_result(es_alu_result), .es_pc(es_pc), .data_ok(data_ok),
    .rdata(rdata), .ms_to_ws_valid(ms_to_ws_valid), .ms_gr_we(ms_gr_we),
    .ms_dest(ms_dest), .ms_result(ms_result), .ms_pc(ms_pc),
    .ms_fwd_valid(ms_fwd_valid), .ms_fwd_ready(ms_fwd_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PC_W-1:0]   pc;
    logic [DEST_W-1:0] dest;
    logic [31:0]       result;
    logic [3:0]        we;
  } exp_t;

  exp_t expq[$];
  int checks = 0;
  int failures = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check32(name, {31'h0, act}, {31'h0, exp});
  endtask

  // Architectural meaning of a MEM result, computed from the load rules.
  function automatic void model(input logic [2:0] op, input logic [31:0] addr,
                                input logic [31:0] word, input logic from_mem,
                                input logic gw, output logic [31:0] res,
                                output logic [3:0] we);
    int a;
    logic [7:0]  b;
    logic [15:0] h;
    logic [3:0]  full;
    a    = int'(addr[1:0]);
    b    = 8'(word >> (8 * a));
    h    = 16'(word >> (16 * (a / 2)));
    full = 4'b1111;
    res  = word;
    case (op)
      3'd1: res = {{24{b[7]}}, b};
      3'd2: res = {24'h0, b};
      3'd3: res = {{16{h[15]}}, h};
      3'd4: res = {16'h0, h};
`ifdef MS_LWLR_EN
      3'd5: begin res = word << (8 * (3 - a)); full = full << (3 - a); end
      3'd6: begin res = word >> (8 * a);       full = full >> a;       end
`endif
      default: res = word;
    endcase
    if (!from_mem) res = addr;
    we = gw ? full : 4'b0000;
  endfunction

  task automatic expect_wb(input logic [PC_W-1:0] pc, input logic [DEST_W-1:0] dest,
                           input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] word, input logic from_mem, input logic gw);
    exp_t e;
    e.pc = pc;
    e.dest = dest;
    model(op, addr, word, from_mem, gw, e.result, e.we);
    expq.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction from EX and hold it until MEM accepts it.
  task automatic issue(input logic [PC_W-1:0] pc, input logic mem_req, input logic from_mem,
                       input logic [2:0] op, input logic gw, input logic [DEST_W-1:0] dest,
                       input logic [31:0] alu);
    int n;
    n = 0;
    es_pc = pc; es_mem_req = mem_req; es_res_from_mem = from_mem; es_ld_op = op;
    es_gr_we = gw; es_dest = dest; es_alu_result = alu; es_to_ms_valid = 1'b1;
    @(negedge clk);
    while (!ms_allowin && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ms_allowin) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout pc=0x%08h actual_allowin=0 required_allowin=1", pc);
    end
    tick();
    es_to_ms_valid = 1'b0; es_mem_req = 1'b0; es_res_from_mem = 1'b0;
    $display("ISSUE pc=0x%08h mem_req=%0d op=%0d addr=0x%08h", pc, mem_req, op, alu);
  endtask

  // Compare every hand-off to WB against the expected-writeback queue.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && ms_to_ws_valid && ws_allowin) begin
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_wb pc=0x%08h actual_valid=1 required_valid=0", ms_pc);
      end else begin
        e = expq.pop_front();
        check32("wb_pc", ms_pc, e.pc);
        check32("wb_dest", {27'h0, ms_dest}, {27'h0, e.dest});
        check32("wb_result", ms_result, e.result);
        check32("wb_we", {28'h0, ms_gr_we}, {28'h0, e.we});
        $display("WB pc=0x%08h dest=%0d result=0x%08h we=%b", ms_pc, ms_dest, ms_result, ms_gr_we);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  op;
    logic        from_mem;
    logic        gw;
    logic [31:0] addr;
    logic [31:0] word;
    logic [31:0] lit;
  } vec_t;

  vec_t vecs[8];

  initial begin
    reset = 1'b1; flush = 1'b0; ws_allowin = 1'b1; es_to_ms_valid = 1'b0;
    es_mem_req = 1'b0; es_res_from_mem = 1'b0; es_ld_op = 3'd0; es_gr_we = 1'b0;
    es_dest = '0; es_alu_result = 32'h0; es_pc = '0; data_ok = 1'b0; rdata = 32'h0;
    repeat (3) tick();

    // Reset state
    @(negedge clk);
    check1("rst_allowin", ms_allowin, 1'b1);
    check1("rst_to_ws_valid", ms_to_ws_valid, 1'b0);
    check32("rst_we", {28'h0, ms_gr_we}, 32'h0);
    check32("rst_result", ms_result, 32'h0);
    check32("rst_pc", ms_pc, 32'h0);
    check1("rst_fwd_valid", ms_fwd_valid, 1'b0);
    check1("rst_fwd_ready", ms_fwd_ready, 1'b0);
    reset = 1'b0;
    tick();

    // ALU pass-through
    expect_wb(32'h100, 5'd3, 3'd0, 32'h1234, 32'h0, 1'b0, 1'b1);
    issue(32'h100, 1'b0, 1'b0, 3'd0, 1'b1, 5'd3, 32'h1234);
    @(negedge clk);
    check1("alu_valid", ms_to_ws_valid, 1'b1);
    check32("alu_we", {28'h0, ms_gr_we}, 32'hF);
    check32("alu_result", ms_result, 32'h1234);
    check1("alu_fwd_valid", ms_fwd_valid, 1'b1);
    tick();

    // LB from offset 3 with a three-cycle response latency
    expect_wb(32'h104, 5'd4, 3'd1, 32'h1003, 32'h80AA55CC, 1'b1, 1'b1);
    issue(32'h104, 1'b1, 1'b1, 3'd1, 1'b1, 5'd4, 32'h1003);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check1("lb_wait_fwd_ready", ms_fwd_ready, 1'b0);
      check1("lb_wait_valid", ms_to_ws_valid, 1'b0);
      tick();
    end
    data_ok = 1'b1; rdata = 32'h80AA55CC;
    @(negedge clk);
    check32("lb_result", ms_result, 32'hFFFFFF80);
    check1("lb_fwd_ready", ms_fwd_ready, 1'b1);
    tick();
    data_ok = 1'b0;

    // LHU from offset 2
    expect_wb(32'h108, 5'd5, 3'd4, 32'h1002, 32'h80AA55CC, 1'b1, 1'b1);
    issue(32'h108, 1'b1, 1'b1, 3'd4, 1'b1, 5'd5, 32'h1002);
    data_ok = 1'b1; rdata = 32'h80AA55CC;
    @(negedge clk);
    check32("lhu_result", ms_result, 32'h000080AA);
    tick();
    data_ok = 1'b0;

    // WB stall: response buffered for two cycles
    ws_allowin = 1'b0;
    expect_wb(32'h10C, 5'd6, 3'd0, 32'h2000, 32'h12345678, 1'b1, 1'b1);
    issue(32'h10C, 1'b1, 1'b1, 3'd0, 1'b1, 5'd6, 32'h2000);
    data_ok = 1'b1; rdata = 32'h12345678;
    tick();
    data_ok = 1'b0; rdata = 32'hDEADBEEF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check32("stall_result", ms_result, 32'h12345678);
      check1("stall_fwd_ready", ms_fwd_ready, 1'b1);
      tick();
    end
    ws_allowin = 1'b1;
    @(negedge clk);
    check1("stall_release_valid", ms_to_ws_valid, 1'b1);
    tick();

    // Load/store table with zero-latency responses
    vecs[0] = '{3'd1, 1'b1, 1'b1, 32'h3000, 32'h7F01FF80, 32'hFFFFFF80};
    vecs[1] = '{3'd2, 1'b1, 1'b1, 32'h3001, 32'h7F01FF80, 32'h000000FF};
    vecs[2] = '{3'd1, 1'b1, 1'b1, 32'h3002, 32'h7F01FF80, 32'h00000001};
    vecs[3] = '{3'd3, 1'b1, 1'b1, 32'h3000, 32'h7F01FF80, 32'hFFFFFF80};
    vecs[4] = '{3'd3, 1'b1, 1'b1, 32'h3002, 32'h7F01FF80, 32'h00007F01};
    vecs[5] = '{3'd4, 1'b1, 1'b1, 32'h3000, 32'h7F01FF80, 32'h0000FF80};
    vecs[6] = '{3'd0, 1'b1, 1'b1, 32'h3004, 32'hCAFEF00D, 32'hCAFEF00D};
    vecs[7] = '{3'd0, 1'b0, 1'b0, 32'h3008, 32'h55555555, 32'h00003008};
    for (int i = 0; i < 8; i++) begin
      expect_wb(32'h120 + 32'(4 * i), 5'(8 + i), vecs[i].op, vecs[i].addr, vecs[i].word,
                vecs[i].from_mem, vecs[i].gw);
      issue(32'h120 + 32'(4 * i), 1'b1, vecs[i].from_mem, vecs[i].op, vecs[i].gw,
            5'(8 + i), vecs[i].addr);
      data_ok = 1'b1; rdata = vecs[i].word;
      @(negedge clk);
      check32("tbl_result", ms_result, vecs[i].lit);
      tick();
      data_ok = 1'b0;
    end

    // LWL / LWR at offset 1
    expect_wb(32'h180, 5'd20, 3'd5, 32'h4001, 32'hAABBCCDD, 1'b1, 1'b1);
    issue(32'h180, 1'b1, 1'b1, 3'd5, 1'b1, 5'd20, 32'h4001);
    data_ok = 1'b1; rdata = 32'hAABBCCDD;
    @(negedge clk);
`ifdef MS_LWLR_EN
    check32("lwl_result_hi", {16'h0, ms_result[31:16]}, 32'h0000CCDD);
    check32("lwl_we", {28'h0, ms_gr_we}, 32'hC);
`else
    check32("lwl_as_lw_result", ms_result, 32'hAABBCCDD);
    check32("lwl_as_lw_we", {28'h0, ms_gr_we}, 32'hF);
`endif
    tick();
    data_ok = 1'b0;
    expect_wb(32'h184, 5'd21, 3'd6, 32'h4001, 32'hAABBCCDD, 1'b1, 1'b1);
    issue(32'h184, 1'b1, 1'b1, 3'd6, 1'b1, 5'd21, 32'h4001);
    data_ok = 1'b1; rdata = 32'hAABBCCDD;
    @(negedge clk);
`ifdef MS_LWLR_EN
    check32("lwr_result_lo", {8'h0, ms_result[23:0]}, 32'h00AABBCC);
    check32("lwr_we", {28'h0, ms_gr_we}, 32'h7);
`else
    check32("lwr_as_lw_result", ms_result, 32'hAABBCCDD);
    check32("lwr_as_lw_we", {28'h0, ms_gr_we}, 32'hF);
`endif
    tick();
    data_ok = 1'b0;

    // Orphaned requests: waiting MEM load plus issued EX load both flushed
    issue(32'h200, 1'b1, 1'b1, 3'd0, 1'b1, 5'd1, 32'h5000);
    es_pc = 32'h204; es_mem_req = 1'b1; es_res_from_mem = 1'b1; es_ld_op = 3'd0;
    es_gr_we = 1'b1; es_dest = 5'd2; es_alu_result = 32'h5004; es_to_ms_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    check1("flush_valid", ms_to_ws_valid, 1'b0);
    tick();
    flush = 1'b0; es_to_ms_valid = 1'b0; es_mem_req = 1'b0;
    expect_wb(32'h208, 5'd7, 3'd0, 32'h5008, 32'h33333333, 1'b1, 1'b1);
    issue(32'h208, 1'b1, 1'b1, 3'd0, 1'b1, 5'd7, 32'h5008);
    for (int i = 0; i < 2; i++) begin
      data_ok = 1'b1; rdata = (i == 0) ? 32'h11111111 : 32'h22222222;
      @(negedge clk);
      check1("stale_drop_valid", ms_to_ws_valid, 1'b0);
      check1("stale_drop_fwd_ready", ms_fwd_ready, 1'b0);
      tick();
    end
    rdata = 32'h33333333;
    @(negedge clk);
    check1("third_resp_valid", ms_to_ws_valid, 1'b1);
    check32("third_resp_result", ms_result, 32'h33333333);
    tick();
    data_ok = 1'b0;

    // Reset while a load waits and one stale response is pending
    es_pc = 32'h2F0; es_mem_req = 1'b1; es_res_from_mem = 1'b1; es_to_ms_valid = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0; es_to_ms_valid = 1'b0; es_mem_req = 1'b0;
    issue(32'h300, 1'b1, 1'b1, 3'd0, 1'b1, 5'd9, 32'h6000);
    @(negedge clk);
    check1("prereset_fwd_ready", ms_fwd_ready, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check1("midrst_allowin", ms_allowin, 1'b1);
    check1("midrst_valid", ms_to_ws_valid, 1'b0);
    check32("midrst_pc", ms_pc, 32'h0);
    check32("midrst_result", ms_result, 32'h0);
    check1("midrst_fwd_ready", ms_fwd_ready, 1'b0);
    data_ok = 1'b1; rdata = 32'h44444444;
    @(negedge clk);
    check1("postrst_ignored", ms_to_ws_valid, 1'b0);
    tick();
    data_ok = 1'b0;
    expect_wb(32'h304, 5'd10, 3'd0, 32'h6004, 32'h55555555, 1'b1, 1'b1);
    issue(32'h304, 1'b1, 1'b1, 3'd0, 1'b1, 5'd10, 32'h6004);
    data_ok = 1'b1; rdata = 32'h55555555;
    @(negedge clk);
    check1("postrst_load_valid", ms_to_ws_valid, 1'b1);
    check32("postrst_load_result", ms_result, 32'h55555555);
    tick();
    data_ok = 1'b0;

    repeat (3) tick();
    check32("exp_queue_drained", 32'(expq.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
